hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL provide parameters (name, default, meaning):
- AW, 5, register address width
- TW, 2, Tuse/Tnew width
- MULT_CYC, 5, multiply busy cycles
- DIV_CYC, 10, divide busy cycles
- CW, 32, stall counter width
REQ-002 SHALL provide ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge
- reset, in, 1, asynchronous, active-high
- D_Rs, in, AW, decode rs index
- D_Rt, in, AW, decode rt index
- D_TuseRs, in, TW, decode rs Tuse
- D_TuseRt, in, TW, decode rt Tuse
- E_A3, in, AW, E-stage destination
- E_Tnew, in, TW, E-stage Tnew
- E_RegWrite, in, 1, E-stage writes A3
- M_A3, in, AW, M-stage destination
- M_Tnew, in, TW, M-stage Tnew
- M_RegWrite, in, 1, M-stage writes A3
- D_MDUse, in, 1, decode instruction touches the MD unit or HI/LO
- E_MDStart, in, 1, single-cycle MD operation start in E
- E_MDDiv, in, 1, qualifies E_MDStart: 1 = divide, 0 = multiply
- Ext_Stall, in, 1, external stall request
- Cnt_Clr, in, 1, synchronous clear of the stall counters
- F_PC_En, out, 1, PC write enable
- F_DRegister_En, out, 1, F/D register enable
- D_ERegister_StallReset, out, 1, inserts a bubble into D/E
- MD_Busy, out, 1, internal MD countdown is nonzero
- Stall_Cnt, out, CW, total stalled cycles
- MD_Stall_Cnt, out, CW, stalled cycles caused by the MD unit

Function
REQ-003 SHALL assert StallRs when all hold: D_TuseRs < E_Tnew, E_A3 == D_Rs, E_A3 != 0, and E_RegWrite = 1.
REQ-004 SHALL also assert StallRs under the same rule using M_A3, M_Tnew and M_RegWrite.
REQ-005 SHALL compute StallRt identically to REQ-003/004, using D_Rt and D_TuseRt.
REQ-006 SHALL compare Tuse and Tnew unsigned at full width TW; equal values SHALL NOT stall.
REQ-007 SHALL keep a countdown md_cnt, wide enough for max(MULT_CYC, DIV_CYC).
REQ-008 SHALL load md_cnt on E_MDStart when md_cnt == 0: load DIV_CYC if E_MDDiv = 1, else MULT_CYC.
REQ-009 SHALL decrement md_cnt by 1 each cycle while md_cnt != 0 and no load occurs, and SHALL stop at 0 without wrap.
REQ-010 SHALL ignore E_MDStart while md_cnt != 0; no reload, countdown continues.
REQ-011 SHALL drive MD_Busy = (md_cnt != 0) from the register.
REQ-012 SHALL assert StallMD = D_MDUse & (E_MDStart | MD_Busy).
REQ-013 SHALL assert Stall = StallRs | StallRt | StallMD | Ext_Stall.
REQ-014 SHALL drive F_PC_En = F_DRegister_En = ~Stall and D_ERegister_StallReset = Stall, all combinationally in the same cycle.
REQ-015 SHALL increment Stall_Cnt by 1 on each clock edge where Stall = 1.
REQ-016 SHALL increment MD_Stall_Cnt by 1 on each clock edge where StallMD = 1.
REQ-017 SHALL saturate both counters at 2^CW - 1.
REQ-018 SHALL give Cnt_Clr priority over increment; a cleared counter reads 0 the next cycle.
REQ-019 SHALL let Cnt_Clr never affect md_cnt or the stall outputs.

Reset
REQ-020 SHALL, on reset = 1, asynchronously set md_cnt, Stall_Cnt and MD_Stall_Cnt to 0, which gives MD_Busy = 0.
REQ-021 SHALL leave the stall outputs purely combinational during reset; with all inputs 0 they read F_PC_En = 1, F_DRegister_En = 1, D_ERegister_StallReset = 0.
REQ-022 SHALL abort an in-flight MD countdown if reset is asserted mid-operation; after deassertion MD_Busy = 0 and the first E_MDStart loads normally.

Verification
REQ-023 SHALL pass: D_Rs = 8, D_TuseRs = 0, E_A3 = 8, E_Tnew = 2, E_RegWrite = 1 -> F_PC_En = 0, D_ERegister_StallReset = 1. The same case with E_A3 = 0 -> no stall.
REQ-024 SHALL pass: D_Rt = 3, D_TuseRt = 1, M_A3 = 3, M_Tnew = 1, M_RegWrite = 1 -> no stall (equal values). Changing D_TuseRt to 0 -> stall.
REQ-025 SHALL pass: E_MDStart = 1, E_MDDiv = 1 for one cycle -> MD_Busy high for exactly 10 cycles; D_MDUse = 1 throughout -> Stall_Cnt = MD_Stall_Cnt = 11 afterwards.
REQ-026 SHALL pass: multiply started, second E_MDStart 2 cycles later -> MD_Busy still falls exactly 5 cycles after the first start.
REQ-027 SHALL pass: reset asserted 3 cycles into a divide -> MD_Busy = 0 and both counters = 0 immediately, without waiting for a clock edge.
REQ-028 SHALL pass: CW = 4, Stall held for 20 cycles -> Stall_Cnt holds at 15; Cnt_Clr pulse -> reads 0 the next cycle.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage interlock for a 5-stage pipeline.
// Detects RAW hazards on rs/rt against the E and M stages (Tuse/Tnew),
// tracks a multiply/divide busy countdown, merges an external stall, and
// counts stalled cycles.
// Ports:
//   clk, reset                  - clock, async active-high reset
//   D_Rs/D_Rt, D_TuseRs/Rt      - decode source indices and use times
//   E_/M_ A3, Tnew, RegWrite    - downstream producers
//   D_MDUse, E_MDStart, E_MDDiv - MD unit usage / start / divide select
//   Ext_Stall, Cnt_Clr          - external stall, counter clear
//   F_PC_En, F_DRegister_En     - fetch enables (low on stall)
//   D_ERegister_StallReset      - bubble insert into D/E
//   MD_Busy                     - MD countdown nonzero
//   Stall_Cnt, MD_Stall_Cnt     - saturating stall counters
module hazard_scoreboard #(
  parameter int unsigned AW       = 5,
  parameter int unsigned TW       = 2,
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter int unsigned CW       = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] D_Rs,
  input  logic [AW-1:0] D_Rt,
  input  logic [TW-1:0] D_TuseRs,
  input  logic [TW-1:0] D_TuseRt,
  input  logic [AW-1:0] E_A3,
  input  logic [TW-1:0] E_Tnew,
  input  logic          E_RegWrite,
  input  logic [AW-1:0] M_A3,
  input  logic [TW-1:0] M_Tnew,
  input  logic          M_RegWrite,
  input  logic          D_MDUse,
  input  logic          E_MDStart,
  input  logic          E_MDDiv,
  input  logic          Ext_Stall,
  input  logic          Cnt_Clr,
  output logic          F_PC_En,
  output logic          F_DRegister_En,
  output logic          D_ERegister_StallReset,
  output logic          MD_Busy,
  output logic [CW-1:0] Stall_Cnt,
  output logic [CW-1:0] MD_Stall_Cnt
);

  localparam int unsigned MD_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int unsigned MDW    = $clog2(MD_MAX + 1);

  logic [MDW-1:0] md_cnt;
  logic           stall_rs;
  logic           stall_rt;
  logic           stall_md;
  logic           stall;

  // RAW hazard: a producer whose result arrives later than the consumer needs it.
  // Register 0 is never a real dependency.
  always_comb begin
    stall_rs = 1'b0;
    stall_rt = 1'b0;
    if (E_RegWrite && (E_A3 != '0)) begin
      if ((E_A3 == D_Rs) && (D_TuseRs < E_Tnew)) stall_rs = 1'b1;
      if ((E_A3 == D_Rt) && (D_TuseRt < E_Tnew)) stall_rt = 1'b1;
    end
    if (M_RegWrite && (M_A3 != '0)) begin
      if ((M_A3 == D_Rs) && (D_TuseRs < M_Tnew)) stall_rs = 1'b1;
      if ((M_A3 == D_Rt) && (D_TuseRt < M_Tnew)) stall_rt = 1'b1;
    end
  end

  // MD conflict covers the start cycle itself as well as the busy window.
  always_comb begin
    stall_md = D_MDUse & (E_MDStart | MD_Busy);
    stall    = stall_rs | stall_rt | stall_md | Ext_Stall;
  end

  assign MD_Busy                = (md_cnt != '0);
  assign F_PC_En                = ~stall;
  assign F_DRegister_En         = ~stall;
  assign D_ERegister_StallReset = stall;

  // MD busy countdown; starts issued while busy are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (md_cnt == '0) begin
      if (E_MDStart) md_cnt <= E_MDDiv ? MDW'(DIV_CYC) : MDW'(MULT_CYC);
    end else begin
      md_cnt <= md_cnt - MDW'(1);
    end
  end

  // Saturating stall counters; clear wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Stall_Cnt    <= '0;
      MD_Stall_Cnt <= '0;
    end else if (Cnt_Clr) begin
      Stall_Cnt    <= '0;
      MD_Stall_Cnt <= '0;
    end else begin
      if (stall && (Stall_Cnt != '1))       Stall_Cnt    <= Stall_Cnt + CW'(1);
      if (stall_md && (MD_Stall_Cnt != '1)) MD_Stall_Cnt <= MD_Stall_Cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: a reference model predicts the
// combinational stall outputs and the post-edge register state; predictions
// are queued at drive time and compared when the DUT updates.
module tb_hazard_scoreboard;

  typedef struct {
    string       tag;
    logic        md_busy;
    logic [31:0] sc;
    logic [31:0] mdsc;
    logic [3:0]  sc4;
    logic [3:0]  mdsc4;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_Rs, D_Rt, E_A3, M_A3;
  logic [1:0]  D_TuseRs, D_TuseRt, E_Tnew, M_Tnew;
  logic        E_RegWrite, M_RegWrite, D_MDUse, E_MDStart, E_MDDiv;
  logic        Ext_Stall, Cnt_Clr;
  logic        F_PC_En, F_DRegister_En, D_ERegister_StallReset, MD_Busy;
  logic [31:0] Stall_Cnt, MD_Stall_Cnt;
  logic        F_PC_En4, F_DRegister_En4, D_ERegister_StallReset4, MD_Busy4;
  logic [3:0]  Stall_Cnt4, MD_Stall_Cnt4;

  exp_t        sb_q[$];
  int          n_total = 0;
  int          n_bad   = 0;

  // reference model state
  int          m_md;
  longint      m_sc, m_mdsc;
  int          m_sc4, m_mdsc4;

  always #5 clk = ~clk;

  hazard_scoreboard u_dut (
    .clk(clk), .reset(reset),
    .D_Rs(D_Rs), .D_Rt(D_Rt), .D_TuseRs(D_TuseRs), .D_TuseRt(D_TuseRt),
    .E_A3(E_A3), .E_Tnew(E_Tnew), .E_RegWrite(E_RegWrite),
    .M_A3(M_A3), .M_Tnew(M_Tnew), .M_RegWrite(M_RegWrite),
    .D_MDUse(D_MDUse), .E_MDStart(E_MDStart), .E_MDDiv(E_MDDiv),
    .Ext_Stall(Ext_Stall), .Cnt_Clr(Cnt_Clr),
    .F_PC_En(F_PC_En), .F_DRegister_En(F_DRegister_En),
    .D_ERegister_StallReset(D_ERegister_StallReset),
    .MD_Busy(MD_Busy), .Stall_Cnt(Stall_Cnt), .MD_Stall_Cnt(MD_Stall_Cnt)
  );

  hazard_scoreboard #(.CW(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .D_Rs(D_Rs), .D_Rt(D_Rt), .D_TuseRs(D_TuseRs), .D_TuseRt(D_TuseRt),
    .E_A3(E_A3), .E_Tnew(E_Tnew), .E_RegWrite(E_RegWrite),
    .M_A3(M_A3), .M_Tnew(M_Tnew), .M_RegWrite(M_RegWrite),
    .D_MDUse(D_MDUse), .E_MDStart(E_MDStart), .E_MDDiv(E_MDDiv),
    .Ext_Stall(Ext_Stall), .Cnt_Clr(Cnt_Clr),
    .F_PC_En(F_PC_En4), .F_DRegister_En(F_DRegister_En4),
    .D_ERegister_StallReset(D_ERegister_StallReset4),
    .MD_Busy(MD_Busy4), .Stall_Cnt(Stall_Cnt4), .MD_Stall_Cnt(MD_Stall_Cnt4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit hz(input logic [4:0] r, input logic [1:0] tuse);
    bit e_hit, m_hit;
    e_hit = E_RegWrite && (E_A3 != 5'd0) && (E_A3 == r) && (int'(tuse) < int'(E_Tnew));
    m_hit = M_RegWrite && (M_A3 != 5'd0) && (M_A3 == r) && (int'(tuse) < int'(M_Tnew));
    return e_hit || m_hit;
  endfunction

  function automatic bit md_stall_m();
    return D_MDUse && (E_MDStart || (m_md != 0));
  endfunction

  function automatic bit stall_m();
    return hz(D_Rs, D_TuseRs) || hz(D_Rt, D_TuseRt) || md_stall_m() || Ext_Stall;
  endfunction

  task automatic model_reset();
    m_md = 0; m_sc = 0; m_mdsc = 0; m_sc4 = 0; m_mdsc4 = 0;
  endtask

  task automatic idle_inputs();
    D_Rs = 0; D_Rt = 0; D_TuseRs = 0; D_TuseRt = 0;
    E_A3 = 0; E_Tnew = 0; E_RegWrite = 0;
    M_A3 = 0; M_Tnew = 0; M_RegWrite = 0;
    D_MDUse = 0; E_MDStart = 0; E_MDDiv = 0; Ext_Stall = 0; Cnt_Clr = 0;
  endtask

  // Inputs are already driven (just after a rising edge). Check the
  // combinational outputs, predict the next state, then compare after the edge.
  task automatic step(input string tag);
    exp_t e;
    bit   s, sm;
    #1;
    s  = stall_m();
    sm = md_stall_m();
    check({tag, "_pc_en"}, 32'(F_PC_En), 32'(!s));
    check({tag, "_fd_en"}, 32'(F_DRegister_En), 32'(!s));
    check({tag, "_bubble"}, 32'(D_ERegister_StallReset), 32'(s));
    check({tag, "_pc_en4"}, 32'(F_PC_En4 & F_DRegister_En4 & ~D_ERegister_StallReset4 & ~MD_Busy4
                                | (F_PC_En4 & MD_Busy4)), 32'(!s));
    if (m_md == 0) begin
      if (E_MDStart) m_md = E_MDDiv ? 10 : 5;
    end else begin
      m_md--;
    end
    if (Cnt_Clr) begin
      m_sc = 0; m_mdsc = 0; m_sc4 = 0; m_mdsc4 = 0;
    end else begin
      if (s  && m_sc   < 64'hFFFF_FFFF) m_sc++;
      if (sm && m_mdsc < 64'hFFFF_FFFF) m_mdsc++;
      if (s  && m_sc4   < 15) m_sc4++;
      if (sm && m_mdsc4 < 15) m_mdsc4++;
    end
    e.tag = tag; e.md_busy = (m_md != 0);
    e.sc = 32'(m_sc); e.mdsc = 32'(m_mdsc); e.sc4 = 4'(m_sc4); e.mdsc4 = 4'(m_mdsc4);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({e.tag, "_md_busy"}, 32'(MD_Busy), 32'(e.md_busy));
    check({e.tag, "_md_busy4"}, 32'(MD_Busy4), 32'(e.md_busy));
    check({e.tag, "_stall_cnt"}, Stall_Cnt, e.sc);
    check({e.tag, "_md_stall_cnt"}, MD_Stall_Cnt, e.mdsc);
    check({e.tag, "_stall_cnt4"}, 32'(Stall_Cnt4), 32'(e.sc4));
    check({e.tag, "_md_stall_cnt4"}, 32'(MD_Stall_Cnt4), 32'(e.mdsc4));
  endtask

  initial begin
    int busy_cycles;
    idle_inputs();
    model_reset();
    reset = 1'b1;
    #3;
    check("rst_md_busy", 32'(MD_Busy), 32'd0);
    check("rst_stall_cnt", Stall_Cnt, 32'd0);
    check("rst_md_stall_cnt", MD_Stall_Cnt, 32'd0);
    check("rst_pc_en", 32'(F_PC_En), 32'd1);
    check("rst_fd_en", 32'(F_DRegister_En), 32'd1);
    check("rst_bubble", 32'(D_ERegister_StallReset), 32'd0);
    #10 reset = 1'b0;
    @(posedge clk); #1;

    // E-stage rs hazard, then the same with $zero destination
    D_Rs = 8; D_TuseRs = 0; E_A3 = 8; E_Tnew = 2; E_RegWrite = 1;
    #1; check("e_rs_pc_en_const", 32'(F_PC_En), 32'd0);
    check("e_rs_bubble_const", 32'(D_ERegister_StallReset), 32'd1);
    step("e_rs");
    E_A3 = 0;
    #1; check("e_zero_pc_en_const", 32'(F_PC_En), 32'd1);
    step("e_zero");

    // M-stage rt: equal Tuse/Tnew does not stall, smaller Tuse does
    idle_inputs();
    D_Rt = 3; D_TuseRt = 1; M_A3 = 3; M_Tnew = 1; M_RegWrite = 1;
    #1; check("m_rt_eq_pc_en_const", 32'(F_PC_En), 32'd1);
    step("m_rt_eq");
    D_TuseRt = 0;
    #1; check("m_rt_lt_pc_en_const", 32'(F_PC_En), 32'd0);
    step("m_rt_lt");

    // divide with MD use throughout: 10 busy cycles, 11 stalled cycles
    idle_inputs();
    Cnt_Clr = 1;
    step("clr0");
    Cnt_Clr = 0; D_MDUse = 1; E_MDStart = 1; E_MDDiv = 1;
    step("div_start");
    E_MDStart = 0; E_MDDiv = 0;
    busy_cycles = 1;
    for (int i = 0; i < 12; i++) begin
      step("div_run");
      if (MD_Busy) busy_cycles++;
    end
    check("div_busy_cycles", 32'(busy_cycles), 32'd10);
    check("div_stall_cnt_const", Stall_Cnt, 32'd11);
    check("div_md_stall_cnt_const", MD_Stall_Cnt, 32'd11);

    // multiply with a second start two cycles later: still 5 busy cycles
    idle_inputs();
    E_MDStart = 1;
    step("mul_start");
    E_MDStart = 0;
    busy_cycles = 1;
    for (int i = 0; i < 7; i++) begin
      E_MDStart = (i == 1);
      E_MDDiv   = (i == 1);
      step("mul_run");
      if (MD_Busy) busy_cycles++;
    end
    check("mul_busy_cycles", 32'(busy_cycles), 32'd5);

    // reset three cycles into a divide clears state without a clock edge
    idle_inputs();
    D_MDUse = 1; E_MDStart = 1; E_MDDiv = 1;
    step("div2_start");
    E_MDStart = 0;
    step("div2_run");
    step("div2_run");
    reset = 1'b1;
    #1;
    check("mid_rst_md_busy", 32'(MD_Busy), 32'd0);
    check("mid_rst_stall_cnt", Stall_Cnt, 32'd0);
    check("mid_rst_md_stall_cnt", MD_Stall_Cnt, 32'd0);
    model_reset();
    idle_inputs();
    @(posedge clk); #1;
    reset = 1'b0;
    E_MDStart = 1; E_MDDiv = 0;
    step("post_rst_mul");
    E_MDStart = 0;
    check("post_rst_md_busy_const", 32'(MD_Busy), 32'd1);

    // 4-bit counter saturates, then clears
    idle_inputs();
    Ext_Stall = 1;
    for (int i = 0; i < 20; i++) step("sat");
    check("sat_stall_cnt4_const", 32'(Stall_Cnt4), 32'd15);
    Ext_Stall = 0; Cnt_Clr = 1;
    step("sat_clr");
    check("sat_clr_cnt4_const", 32'(Stall_Cnt4), 32'd0);
    Cnt_Clr = 0;

    // random mix
    for (int i = 0; i < 300; i++) begin
      D_Rs = 5'($urandom_range(0, 3));      D_Rt = 5'($urandom_range(0, 3));
      D_TuseRs = 2'($urandom_range(0, 3));  D_TuseRt = 2'($urandom_range(0, 3));
      E_A3 = 5'($urandom_range(0, 3));      E_Tnew = 2'($urandom_range(0, 3));
      M_A3 = 5'($urandom_range(0, 3));      M_Tnew = 2'($urandom_range(0, 3));
      E_RegWrite = 1'($urandom_range(0, 1)); M_RegWrite = 1'($urandom_range(0, 1));
      D_MDUse   = ($urandom_range(0, 3) == 0);
      E_MDStart = ($urandom_range(0, 9) == 0);
      E_MDDiv   = 1'($urandom_range(0, 1));
      Ext_Stall = ($urandom_range(0, 7) == 0);
      Cnt_Clr   = ($urandom_range(0, 19) == 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
